// File: rtl/vc_output_allocator.sv
// Output-port VC allocator: round-robin picks one requesting VC, locks the port
// to it until its tail flit transfers, and registers the forwarded flit.

module vc_oa_lane #(
  parameter int FLIT_W = 10,
  parameter int IW     = 2,
  parameter int LANE   = 0
) (
  input  logic              active,
  input  logic [IW-1:0]     g,
  input  logic              rdy,
  input  logic              data_vld,
  input  logic [FLIT_W-1:0] flit,
  output logic              grant,
  output logic              chan_rdy,
  output logic              xfer,
  output logic [FLIT_W-1:0] flit_sel
);
  logic sel;
  assign sel      = active && (g == IW'(LANE));
  assign grant    = sel;
  assign chan_rdy = sel & rdy;
  assign xfer     = sel & rdy & data_vld;
  assign flit_sel = sel ? flit : '0;
endmodule

module vc_output_allocator #(
  parameter int IN_N        = 4,
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IN_N-1:0]          req_i,
  input  logic [IN_N*(FLIT_ID_W+FLIT_DATA_W)-1:0] data_i,
  input  logic [IN_N-1:0]          data_vld_i,
  input  logic                     rdy_i,
  output logic [IN_N-1:0]          grant_o,
  output logic [IN_N-1:0]          chan_rdy_o,
  output logic [FLIT_ID_W+FLIT_DATA_W-1:0] data_o,
  output logic                     vld_o,
  output logic                     busy_o,
  output logic                     err_o
);
  localparam int FLIT_W = FLIT_ID_W + FLIT_DATA_W;
  localparam int IW     = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam logic [FLIT_ID_W-1:0] HEADER_ID = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] BODY_ID   = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] TAIL_ID   = FLIT_ID_W'(3);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [IW-1:0] g_q, g_d, ptr_q, ptr_d, pick;
  logic          first_q, first_d, found;
  logic          active;
  logic [IN_N-1:0]             xfer_v;
  logic [IN_N-1:0][FLIT_W-1:0] lane_flit;
  logic [FLIT_W-1:0]           flit_g;
  logic                        xfer;
  logic [FLIT_ID_W-1:0]        flit_type;

  assign active = (state_q == ACTIVE);
  assign busy_o = active;

  for (genvar i = 0; i < IN_N; i++) begin : g_lane
    vc_oa_lane #(.FLIT_W(FLIT_W), .IW(IW), .LANE(i)) u_lane (
      .active  (active),
      .g       (g_q),
      .rdy     (rdy_i),
      .data_vld(data_vld_i[i]),
      .flit    (data_i[i*FLIT_W +: FLIT_W]),
      .grant   (grant_o[i]),
      .chan_rdy(chan_rdy_o[i]),
      .xfer    (xfer_v[i]),
      .flit_sel(lane_flit[i])
    );
  end

  // Only the granted lane contributes a non-zero flit, so OR acts as the mux.
  always_comb begin
    flit_g = '0;
    for (int i = 0; i < IN_N; i++) flit_g = flit_g | lane_flit[i];
  end

  assign xfer      = |xfer_v;
  assign flit_type = flit_g[FLIT_W-1 -: FLIT_ID_W];

  // Round-robin search starts one past the last granted VC.
  always_comb begin
    logic [IW-1:0] idx_w;
    found = 1'b0;
    pick  = ptr_q;
    idx_w = '0;
    for (int k = 1; k <= IN_N; k++) begin
      idx_w = IW'((int'(ptr_q) + k) % IN_N);
      if (!found && req_i[idx_w]) begin
        found = 1'b1;
        pick  = idx_w;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= IW'(IN_N - 1);
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ACTIVE;
        g_d     = pick;
        first_d = 1'b1;
      end
      ACTIVE: if (xfer) begin
        first_d = 1'b0;
        if (flit_type == TAIL_ID) begin
          state_d = IDLE;
          ptr_d   = g_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o <= '0;
      vld_o  <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      vld_o <= xfer;
      if (xfer) data_o <= flit_g;
      // A header after the first flit means the upstream VC lost packet framing.
      if (xfer && flit_type == HEADER_ID && !first_q) err_o <= 1'b1;
    end
  end

  logic unused_body_id;
  assign unused_body_id = ^BODY_ID;
endmodule
